// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and opcodes for the MIPS memory stage
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_NONE = 2'b11
    } access_sz_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mm_state_t;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    function automatic logic is_aligned(input access_sz_t sz, input logic [1:0] lo);
        case (sz)
            SZ_WORD: is_aligned = (lo == 2'b00);
            SZ_HALF: is_aligned = ~lo[0];
            default: is_aligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mm_load_align.sv
// rtl/mm_load_align.sv - little-endian lane select and sign/zero extension of load data
module mm_load_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  access_sz_t  sz,
    input  logic [5:0]  opcode,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sext;

    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        sext   = (opcode == OP_LB) || (opcode == OP_LH);
        case (sz)
            SZ_BYTE: data = {{24{sext & lane_b[7]}}, lane_b};
            SZ_HALF: data = {{16{sext & lane_h[15]}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mm_stage.sv
// rtl/mm_stage.sv - MIPS memory stage: data-memory handshake, store lanes, MEM/WB register
module mm_stage
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_out_alu_ex_mm,
    input  logic [31:0] rd1_data_ex_mm,
    input  logic [1:0]  dm_access_sz_ex_mm,
    input  logic        dm_rw_ex_mm,
    input  logic [31:0] pc_ex_mm,
    input  logic        wr_en_reg_ex_mm,
    input  logic [4:0]  wr_num_ex_mm,
    input  logic [5:0]  opcode_ex_mm,
    input  logic        flushw,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall_mm,
    output logic [31:0] wr_data_mm_wb,
    output logic [4:0]  wr_num_mm_wb,
    output logic        wr_en_reg_mm_wb,
    output logic [31:0] pc_mm_wb,
    output logic        misalign_exc,
    output logic        bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    access_sz_t       sz;
    mm_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             mem_op, aligned, timeout_hit;
    logic             req, stall, complete, abort;
    logic [3:0]       be;
    logic [31:0]      load_data;

    assign sz          = access_sz_t'(dm_access_sz_ex_mm);
    assign mem_op      = (sz != SZ_NONE);
    assign aligned     = is_aligned(sz, data_out_alu_ex_mm[1:0]);
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == WAIT && state_nxt == WAIT) ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        stall     = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && aligned) begin
                    req = 1'b1;
                    if (dm_ack) begin
                        complete = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (dm_ack) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Bus strobes must fall the instant reset asserts, not at the next edge.
        if (!rst_n) begin
            req      = 1'b0;
            stall    = 1'b0;
            complete = 1'b0;
            abort    = 1'b0;
        end
    end

    always_comb begin
        case (sz)
            SZ_BYTE: begin
                be       = 4'b0001 << data_out_alu_ex_mm[1:0];
                dm_wdata = {4{rd1_data_ex_mm[7:0]}};
            end
            SZ_HALF: begin
                be       = 4'b0011 << data_out_alu_ex_mm[1:0];
                dm_wdata = {2{rd1_data_ex_mm[15:0]}};
            end
            default: begin
                be       = 4'b1111;
                dm_wdata = rd1_data_ex_mm;
            end
        endcase
    end

    assign dm_req   = req;
    assign dm_we    = req & dm_rw_ex_mm;
    assign dm_be    = dm_we ? be : 4'b0000;
    assign dm_addr  = {data_out_alu_ex_mm[31:2], 2'b00};
    assign stall_mm = stall;

    mm_load_align u_load_align (
        .addr_lo (data_out_alu_ex_mm[1:0]),
        .sz      (sz),
        .opcode  (opcode_ex_mm),
        .rdata   (dm_rdata),
        .data    (load_data)
    );

    // Stalled or flushed cycles load a bubble; stores, misaligned and aborted ops never write a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flushw || stall) begin
            wr_data_mm_wb   <= '0;
            wr_num_mm_wb    <= '0;
            wr_en_reg_mm_wb <= 1'b0;
            pc_mm_wb        <= '0;
            misalign_exc    <= 1'b0;
            bus_err         <= 1'b0;
        end else begin
            wr_num_mm_wb <= wr_num_ex_mm;
            pc_mm_wb     <= pc_ex_mm;
            misalign_exc <= mem_op && !aligned;
            bus_err      <= abort;
            if (complete && !dm_rw_ex_mm) begin
                wr_data_mm_wb   <= load_data;
                wr_en_reg_mm_wb <= wr_en_reg_ex_mm;
            end else begin
                wr_data_mm_wb   <= data_out_alu_ex_mm;
                wr_en_reg_mm_wb <= wr_en_reg_ex_mm && !mem_op;
            end
        end
    end

endmodule
